// File: rtl/xlr8_lfsr_sched.sv
// xlr8_lfsr_sched: round-robin scheduler sharing one alorium_lfsr core among
// NUM_REQ requesters. Each grant steps the core once and hands back exactly one
// fresh word; seed writes are queued ahead of requests and zero seeds are
// replaced by SEED_INIT so the core never locks up.
// Optional feature: define XLR8_LFSR_SCHED_LOCK_EN to let a locked previous
// winner keep the grant (burst mode); otherwise req_lock is ignored.
module xlr8_lfsr_sched #(
  parameter int unsigned      NUM_REQ   = 4,
  parameter int unsigned      WIDTH     = 8,
  parameter logic [WIDTH-1:0] SEED_INIT = WIDTH'(1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clken,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] req_lock,
  input  logic               seed_we,
  input  logic [WIDTH-1:0]   seed_in,
  output logic               rnd_valid,
  output logic [NUM_REQ-1:0] rnd_gnt,
  output logic [WIDTH-1:0]   rnd_data,
  output logic               busy,
  output logic               lfsr_new_seed,
  output logic               lfsr_enable,
  output logic [WIDTH-1:0]   lfsr_seed,
  input  logic [WIDTH-1:0]   lfsr_data
);

  localparam int unsigned    IW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [IW:0]    NREQ      = (IW+1)'(NUM_REQ);
  localparam logic [IW-1:0]  LAST_INIT = IW'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    IDLE,
    SEED,
    STEP,
    CAPT
  } state_t;

  state_t               r_state;
  logic [WIDTH-1:0]     r_seed;
  logic                 r_seed_pend;
  logic [IW-1:0]        r_last;
  logic [IW-1:0]        r_win;
  logic                 r_rnd_valid;
  logic [NUM_REQ-1:0]   r_rnd_gnt;
  logic [WIDTH-1:0]     r_rnd_data;

  logic                 w_found;
  logic [IW-1:0]        w_win;
  logic [IW:0]          w_cand;
  logic [NUM_REQ-1:0]   w_win_oh;
  logic [WIDTH-1:0]     w_seed_wr;

`ifndef XLR8_LFSR_SCHED_LOCK_EN
  logic                 w_unused_lock;
  assign w_unused_lock = ^req_lock;
`endif

  // Round-robin search starting one past the last winner (optionally lock-held)
  always_comb begin
    w_found = 1'b0;
    w_win   = r_last;
    w_cand  = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      w_cand = {1'b0, r_last} + (IW+1)'(i);
      if (w_cand >= NREQ) begin
        w_cand = w_cand - NREQ;
      end
      if (!w_found && req[w_cand[IW-1:0]]) begin
        w_found = 1'b1;
        w_win   = w_cand[IW-1:0];
      end
    end
`ifdef XLR8_LFSR_SCHED_LOCK_EN
    if (req[r_last] && req_lock[r_last]) begin
      w_found = 1'b1;
      w_win   = r_last;
    end
`endif
  end

  // One-hot form of the latched winner for the delivery register
  always_comb begin
    w_win_oh        = '0;
    w_win_oh[r_win] = 1'b1;
  end

  assign w_seed_wr = (seed_in == '0) ? SEED_INIT : seed_in;

  // Scheduler FSM, seed register and registered delivery outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_seed      <= SEED_INIT;
      r_seed_pend <= 1'b1;
      r_last      <= LAST_INIT;
      r_win       <= '0;
      r_rnd_valid <= 1'b0;
      r_rnd_gnt   <= '0;
      r_rnd_data  <= '0;
    end else if (clken) begin
      r_rnd_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          // a write arriving this cycle counts as pending so SEED follows next
          if (r_seed_pend || seed_we) begin
            r_state <= SEED;
          end else if (w_found) begin
            r_win   <= w_win;
            r_last  <= w_win;
            r_state <= STEP;
          end
        end
        SEED: begin
          r_seed_pend <= 1'b0;
          r_state     <= IDLE;
        end
        STEP: begin
          r_state <= CAPT;
        end
        CAPT: begin
          r_rnd_data  <= lfsr_data;
          r_rnd_gnt   <= w_win_oh;
          r_rnd_valid <= 1'b1;
          r_state     <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
      // placed last so a write during SEED keeps the pending flag set
      if (seed_we) begin
        r_seed      <= w_seed_wr;
        r_seed_pend <= 1'b1;
      end
    end
  end

  assign lfsr_new_seed = (r_state == SEED) && clken;
  assign lfsr_enable   = (r_state == STEP) && clken;
  assign lfsr_seed     = r_seed;
  assign busy          = (r_state != IDLE) || r_seed_pend;
  assign rnd_valid     = r_rnd_valid;
  assign rnd_gnt       = r_rnd_gnt;
  assign rnd_data      = r_rnd_data;

endmodule

// File: tb/tb_xlr8_lfsr_sched.sv
// tb_xlr8_lfsr_sched: randomized bench with a transaction-level reference
// model (job type + elapsed enabled cycles) and a behavioural LFSR core.
module tb_xlr8_lfsr_sched;

  localparam int         N     = 4;
  localparam int         W     = 8;
  localparam logic [7:0] SINIT = 8'h01;

  logic         clk;
  logic         rst;
  logic         clken;
  logic [N-1:0] req;
  logic [N-1:0] req_lock;
  logic         seed_we;
  logic [W-1:0] seed_in;
  logic         rnd_valid;
  logic [N-1:0] rnd_gnt;
  logic [W-1:0] rnd_data;
  logic         busy;
  logic         lfsr_new_seed;
  logic         lfsr_enable;
  logic [W-1:0] lfsr_seed;
  logic [W-1:0] lfsr_data;

  int n_checks = 0;
  int n_fail   = 0;

  xlr8_lfsr_sched #(
    .NUM_REQ   (N),
    .WIDTH     (W),
    .SEED_INIT (SINIT)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .clken         (clken),
    .req           (req),
    .req_lock      (req_lock),
    .seed_we       (seed_we),
    .seed_in       (seed_in),
    .rnd_valid     (rnd_valid),
    .rnd_gnt       (rnd_gnt),
    .rnd_data      (rnd_data),
    .busy          (busy),
    .lfsr_new_seed (lfsr_new_seed),
    .lfsr_enable   (lfsr_enable),
    .lfsr_seed     (lfsr_seed),
    .lfsr_data     (lfsr_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Galois LFSR step, taps 0xB8
  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    return v[0] ? ((v >> 1) ^ 8'hB8) : (v >> 1);
  endfunction

  // Behavioural stand-in for the alorium_lfsr core (not reset by rst)
  logic [7:0] core_q;
  initial core_q = 8'h00;
  always @(posedge clk) begin
    if (lfsr_new_seed) core_q <= lfsr_seed;
    else if (lfsr_enable) core_q <= lfsr_next(core_q);
  end
  assign lfsr_data = core_q;

  // Reference model: kind 0 = free, 1 = reseeding, 2 = delivering (m_t = cycles since grant)
  logic [7:0]   m_seed;
  logic         m_pend;
  int           m_last;
  logic [7:0]   m_lfsr;
  int           m_kind;
  int           m_t;
  int           m_win;
  logic         m_val;
  logic [N-1:0] m_gnt;
  logic [7:0]   m_data;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_seed = SINIT;
    m_pend = 1'b1;
    m_last = N - 1;
    m_kind = 0;
    m_t    = 0;
    m_win  = 0;
    m_val  = 1'b0;
    m_gnt  = '0;
    m_data = '0;
  endtask

  function automatic int pick();
`ifdef XLR8_LFSR_SCHED_LOCK_EN
    if (req[m_last] && req_lock[m_last]) return m_last;
`endif
    for (int k = 1; k <= N; k++) begin
      if (req[(m_last + k) % N]) return (m_last + k) % N;
    end
    return -1;
  endfunction

  // Advance the model across one enabled clock edge using the current inputs
  task automatic model_edge();
    logic old_pend;
    int   w;
    old_pend = m_pend;
    m_val    = 1'b0;
    if (m_kind == 2 && m_t == 2) begin
      m_val  = 1'b1;
      m_gnt  = N'(1 << m_win);
      m_data = m_lfsr;
    end
    if (m_kind == 1) begin
      m_lfsr = m_seed;
      m_pend = 1'b0;
      m_kind = 0;
    end else if (m_kind == 2) begin
      if (m_t == 1) begin
        m_lfsr = lfsr_next(m_lfsr);
        m_t    = 2;
      end else begin
        m_kind = 0;
      end
    end else begin
      if (old_pend || seed_we) begin
        m_kind = 1;
        m_t    = 1;
      end else begin
        w = pick();
        if (w >= 0) begin
          m_kind = 2;
          m_t    = 1;
          m_win  = w;
          m_last = w;
        end
      end
    end
    if (seed_we) begin
      m_seed = (seed_in == 8'h00) ? SINIT : seed_in;
      m_pend = 1'b1;
    end
  endtask

  task automatic check_outputs();
    chk("rnd_valid", 32'(rnd_valid), 32'(m_val));
    chk("rnd_gnt", 32'(rnd_gnt), 32'(m_gnt));
    chk("rnd_data", 32'(rnd_data), 32'(m_data));
    chk("busy", 32'(busy), 32'(m_kind != 0 || m_pend));
    chk("new_seed", 32'(lfsr_new_seed), 32'(clken && !rst && m_kind == 1));
    chk("enable", 32'(lfsr_enable), 32'(clken && !rst && m_kind == 2 && m_t == 1));
    chk("lfsr_seed", 32'(lfsr_seed), 32'(m_seed));
    chk("ctrl_excl", 32'(lfsr_new_seed & lfsr_enable), 32'(0));
  endtask

  // Entered at a negedge with inputs already driven; returns at the next negedge
  task automatic tick();
    #1;
    check_outputs();
    if (!rst && clken) model_edge();
    @(negedge clk);
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    #1;
    model_reset();
    check_outputs();
    @(negedge clk);
    repeat (cycles) tick();
    rst = 1'b0;
  endtask

  // Requesters: drop on own delivery unless keeping (keep_pct), raise randomly
  task automatic drive_req(input int keep_pct, input int raise_pct);
    for (int i = 0; i < N; i++) begin
      if (req[i] && m_val && m_gnt[i]) begin
        if ($urandom_range(0, 99) >= keep_pct) req[i] = 1'b0;
      end else if (!req[i] && $urandom_range(0, 99) < raise_pct) begin
        req[i] = 1'b1;
      end
    end
  endtask

  initial begin
    rst      = 1'b1;
    clken    = 1'b1;
    req      = '0;
    req_lock = '0;
    seed_we  = 1'b0;
    seed_in  = '0;
    m_lfsr   = 8'h00;

    // reset seeding
    do_reset(2);
    repeat (4) tick();

    // single request then drop on delivery
    req = 4'b0001;
    repeat (6) begin drive_req(0, 0); tick(); end

    // rotation with all requests held
    req = 4'b1111;
    repeat (15) tick();
    req = '0;
    repeat (4) tick();

    // zero seed with a competing request
    req     = 4'b0010;
    seed_we = 1'b1;
    seed_in = 8'h00;
    tick();
    seed_we = 1'b0;
    repeat (6) begin drive_req(0, 0); tick(); end

    // clock-enable stall during STEP
    req = 4'b0100;
    for (int k = 0; k < 20 && !(m_kind == 2 && m_t == 1); k++) tick();
    #1;
    chk("reach_step", 32'(lfsr_enable), 32'(1));
    clken = 1'b0;
    repeat (5) tick();
    clken = 1'b1;
    repeat (6) begin drive_req(0, 0); tick(); end

    // lock behaviour (or plain alternation without the lock build)
    req      = 4'b0011;
    req_lock = 4'b0001;
    repeat (10) tick();
    req      = '0;
    req_lock = '0;
    repeat (4) tick();

    // reset pulse during CAPT
    req = 4'b1000;
    for (int k = 0; k < 20 && !(m_kind == 2 && m_t == 2); k++) tick();
    chk("reach_capt", 32'(busy), 32'(1));
    do_reset(1);
    req = '0;
    repeat (5) tick();

    // randomized traffic
    for (int c = 0; c < 1500; c++) begin
      clken    = ($urandom_range(0, 9) != 0);
      seed_we  = ($urandom_range(0, 19) == 0);
      seed_in  = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      req_lock = N'($urandom);
      drive_req(30, 40);
      if ($urandom_range(0, 399) == 0) do_reset(1);
      else tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/xlr8_lfsr_sched.md
# xlr8_lfsr_sched

Round-robin scheduler that shares a single `alorium_lfsr` core between up to `NUM_REQ` hardware requesters inside an XLR8 XB. It sequences the core's seed-load and step controls so that every grant delivers exactly one fresh LFSR word. It also guarantees the core is never seeded with zero. The block sits between the requesting XB logic and the LFSR core, replacing direct register-driven control of `new_seed` and `enable`.

## Interface

**Parameters**
- `NUM_REQ`, 4 — number of requesters, 2..8.
- `WIDTH`, 8 — LFSR word width.
- `SEED_INIT`, 8'h01 — reset seed, and the substitute for any zero seed write; must be nonzero.

**Ports**
- `clk` input 1 — single clock, rising edge.
- `rst` input 1 — asynchronous, active-high reset.
- `clken` input 1 — clock enable; all registers update only when high.
- `req` input NUM_REQ — level request per requester; held until granted.
- `req_lock` input NUM_REQ — burst lock per requester. Used only with `XLR8_LFSR_SCHED_LOCK_EN`.
- `seed_we` input 1 — seed write strobe.
- `seed_in` input WIDTH — seed value.
- `rnd_valid` output 1 — delivered word valid.
- `rnd_gnt` output NUM_REQ — one-hot owner of `rnd_data`; qualified by `rnd_valid`.
- `rnd_data` output WIDTH — delivered LFSR word.
- `busy` output 1 — high when the FSM is not IDLE or a seed is pending.
- `lfsr_new_seed` output 1 — to core `new_seed`.
- `lfsr_enable` output 1 — to core `enable`.
- `lfsr_seed` output WIDTH — to core `seed`; equals the seed register.
- `lfsr_data` input WIDTH — from core; updates on the edge where `enable` is sampled high.

## Operation

**FSM states:** IDLE, SEED, STEP, CAPT. Reset state is IDLE.

**IDLE**
- If `seed_pend` = 1, go to SEED.
- Otherwise, if any `req` bit is high, latch the round-robin winner and go to STEP.
- Otherwise, stay in IDLE.

**SEED**
- `lfsr_new_seed` = `clken`.
- Clear `seed_pend`.
- Go to IDLE.

**STEP**
- `lfsr_enable` = `clken`.
- Go to CAPT.

**CAPT**
- Register `rnd_data` ← `lfsr_data`.
- Register `rnd_gnt` ← winner one-hot.
- Register `rnd_valid` ← 1.
- Go to IDLE.

**Seed handling**
- `seed_we` captures `seed_in` into the seed register in any state and sets `seed_pend`.
- A zero `seed_in` is stored as `SEED_INIT`.
- Back-to-back writes overwrite the register. One reseed then uses the last value.
- `seed_we` in the SEED cycle: the new value is stored and `seed_pend` stays set, so a second SEED pass follows.

**Arbitration**
- Round-robin search begins at the index after the last winner.
- After reset the last-winner pointer is NUM_REQ-1, so `req[0]` has first priority.
- A pending seed always beats requests.

**Other behaviour**
- Requests are not dropped. An ungranted requester waits at most NUM_REQ-1 deliveries, plus any reseeds.
- `lfsr_new_seed` and `lfsr_enable` are combinational from state and `clken`. They are never high together.

**Reset values**
- Seed register = `SEED_INIT`; `seed_pend` = 1. The core is therefore seeded first after reset.
- `rnd_valid` = 0, `rnd_gnt` = 0, `rnd_data` = 0.
- `busy` = 1, because `seed_pend` = 1.
- Last-winner pointer = NUM_REQ-1.
- Reset mid-operation aborts any transfer and emits no `rnd_valid`.

## Timing

All counts below are cycles with `clken` = 1. When `clken` = 0, state and outputs hold.

**Request to data latency**
- Cycle 0: `req` sampled in IDLE.
- Cycle 1: STEP.
- Cycle 2: CAPT.
- Cycle 3: `rnd_valid` = 1 for one enabled cycle, with `rnd_gnt` and `rnd_data` stable. The FSM is IDLE in this cycle and can arbitrate.
- Sustained throughput is one word per 3 cycles.

**Requester handshake**
- The requester must drop `req` in the cycle `rnd_valid` and its `rnd_gnt` bit are high, unless it wants another word.
- A `req` still high in that cycle is eligible in the same cycle's arbitration.

**Seed latency**
- `seed_we` in IDLE with no transfer in progress: SEED is the next cycle.
- From then, the next STEP uses the new sequence.

## Configuration

`XLR8_LFSR_SCHED_LOCK_EN`:
- **Defined:** if the previous winner's `req` and `req_lock` bits are both high in IDLE, it wins again, bypassing rotation. A pending seed still takes precedence.
- **Undefined:** `req_lock` is ignored and arbitration is strict round-robin. The port remains present.

## Test plan

1. **Reset seeding:** release reset with no `req` → SEED in cycle 1 with `lfsr_seed` = 8'h01; `busy` falls after it; no `rnd_valid`.
2. **Single request:** `req` = 4'b0001 at cycle 0 → `lfsr_enable` high in cycle 1 only; cycle 3 shows `rnd_valid` = 1, `rnd_gnt` = 4'b0001, `rnd_data` equal to the core's next word.
3. **Rotation:** `req` = 4'b1111 held → grant order 0, 1, 2, 3, 0, each 3 cycles apart.
4. **Zero seed and seed priority:** `seed_we` with `seed_in` = 8'h00 while `req` = 4'b0010 → SEED with `lfsr_seed` = 8'h01 runs before the STEP for requester 1.
5. **`clken` stall:** `clken` = 0 for 5 cycles during STEP → `lfsr_enable` = 0 and outputs hold; delivery resumes with the total latency extended by exactly 5.
6. **Lock and reset abort:**
   - With `XLR8_LFSR_SCHED_LOCK_EN`: `req` = 4'b0011 and `req_lock` = 4'b0001 → requester 0 receives 3 consecutive words.
   - Without the macro: grants alternate 0, 1, 0.
   - `rst` pulsed in CAPT → no `rnd_valid`, and the FSM restarts with SEED.
